// File: rtl/bitwise_logic_unit_pkg.sv
// Shared ALU definitions: logic-op encoding and the slice-serial FSM state encoding.
package bitwise_logic_unit_pkg;

    // Logic operation select
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/bitwise_slice.sv
// Combinational SLICE-wide logic cell: y = a <op> b.
module bitwise_slice
    import bitwise_logic_unit_pkg::*;
#(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [1:0]       op,
    output logic [SLICE-1:0] y
);

    // Decode the operation for one slice
    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Slice-serial bitwise logic unit: processes SLICE bits of A op B per cycle with a
// start/busy/done handshake and a sticky nonzero flag for branch/flag logic.
module bitwise_logic_unit
    import bitwise_logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             result_nonzero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    // Keep the index at least one bit wide so NSLICE == 1 still elaborates
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((SLICE == 0) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
        $error("bitwise_logic_unit: WIDTH must be a nonzero multiple of SLICE");
    end

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             nz_q, nz_d;
    logic [SLICE-1:0] a_sl, b_sl, y_sl;
    logic             last_slice;
    logic             accept;

    assign accept     = (state_q == ST_IDLE) && ctrl_start;
    assign last_slice = (idx_q == IDXW'(NSLICE - 1));

    // Select the current operand slice from the captured operands
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < int'(NSLICE); i++) begin
            if (idx_q == IDXW'(i)) begin
                a_sl = a_q[i*SLICE +: SLICE];
                b_sl = b_q[i*SLICE +: SLICE];
            end
        end
    end

    bitwise_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .op (op_q),
        .y  (y_sl)
    );

    // Next-state: FSM sequencing, slice write-back and nonzero accumulation
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        result_d = result_q;
        nz_d     = nz_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_start) begin
                    state_d  = ST_RUN;
                    idx_d    = '0;
                    result_d = '0;
                    nz_d     = 1'b0;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < int'(NSLICE); i++) begin
                    if (idx_q == IDXW'(i)) begin
                        result_d[i*SLICE +: SLICE] = y_sl;
                    end
                end
                nz_d = nz_q | (|y_sl);
                if (last_slice) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, result and flag registers; async reset aborts any operation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            result_q <= '0;
            nz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            nz_q     <= nz_d;
        end
    end

    // Operand/op capture on an accepted start only; later input changes are ignored
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_AND;
        end else if (accept) begin
            a_q  <= data_operandA;
            b_q  <= data_operandB;
            op_q <= op;
        end
    end

    assign data_result    = result_q;
    assign result_nonzero = nz_q;
    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit: directed vector table, reset/handshake
// sequences and a randomized parameter sweep against a behavioural model.
module tb_bitwise_logic_unit;

    logic clock;
    logic reset;

    // Instance 0: 32/8, instance 1: 32/32, instance 2: 16/4, instance 3: 64/8
    logic        st0, st1, st2, st3;
    logic [1:0]  op0, op1, op2, op3;
    logic [31:0] a0, b0, r0, a1, b1, r1;
    logic [15:0] a2, b2, r2;
    logic [63:0] a3, b3, r3;
    logic        nz0, nz1, nz2, nz3;
    logic        bz0, bz1, bz2, bz3;
    logic        dn0, dn1, dn2, dn3;

    int checks = 0;
    int errors = 0;

    bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) u_dut0 (
        .clock(clock), .reset(reset), .ctrl_start(st0), .op(op0),
        .data_operandA(a0), .data_operandB(b0), .data_result(r0),
        .result_nonzero(nz0), .busy(bz0), .done(dn0));
    bitwise_logic_unit #(.WIDTH(32), .SLICE(32)) u_dut1 (
        .clock(clock), .reset(reset), .ctrl_start(st1), .op(op1),
        .data_operandA(a1), .data_operandB(b1), .data_result(r1),
        .result_nonzero(nz1), .busy(bz1), .done(dn1));
    bitwise_logic_unit #(.WIDTH(16), .SLICE(4)) u_dut2 (
        .clock(clock), .reset(reset), .ctrl_start(st2), .op(op2),
        .data_operandA(a2), .data_operandB(b2), .data_result(r2),
        .result_nonzero(nz2), .busy(bz2), .done(dn2));
    bitwise_logic_unit #(.WIDTH(64), .SLICE(8)) u_dut3 (
        .clock(clock), .reset(reset), .ctrl_start(st3), .op(op3),
        .data_operandA(a3), .data_operandB(b3), .data_result(r3),
        .result_nonzero(nz3), .busy(bz3), .done(dn3));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_nz;
    } vec_t;

    function automatic int nslice(input int inst);
        case (inst)
            0: return 4;
            1: return 1;
            2: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int width(input int inst);
        case (inst)
            0: return 32;
            1: return 32;
            2: return 16;
            default: return 64;
        endcase
    endfunction

    // Reference: whole-word operation, truncated to the instance width
    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
        logic [63:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a | b);
        endcase
        if (w < 64) r = r & ((64'd1 << w) - 64'd1);
        return r;
    endfunction

    function automatic logic [63:0] get_r(input int inst);
        case (inst)
            0: return {32'd0, r0};
            1: return {32'd0, r1};
            2: return {48'd0, r2};
            default: return r3;
        endcase
    endfunction

    // Returns {nonzero, busy, done}
    function automatic logic [2:0] get_f(input int inst);
        case (inst)
            0: return {nz0, bz0, dn0};
            1: return {nz1, bz1, dn1};
            2: return {nz2, bz2, dn2};
            default: return {nz3, bz3, dn3};
        endcase
    endfunction

    task automatic drive(input int inst, input logic s, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        case (inst)
            0: begin st0 = s; op0 = op; a0 = a[31:0]; b0 = b[31:0]; end
            1: begin st1 = s; op1 = op; a1 = a[31:0]; b1 = b[31:0]; end
            2: begin st2 = s; op2 = op; a2 = a[15:0]; b2 = b[15:0]; end
            default: begin st3 = s; op3 = op; a3 = a; b3 = b; end
        endcase
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One full operation starting in the current cycle (cycle 0); checks exact timing
    task automatic do_op(input int inst, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input string tag);
        int n;
        logic [63:0] exp;
        logic [2:0]  f;
        n   = nslice(inst);
        exp = ref_op(op, a, b, width(inst));
        drive(inst, 1'b1, op, a, b);
        tick();
        // Scramble inputs after capture: must not affect the result
        drive(inst, 1'b0, ~op, {$urandom, $urandom}, {$urandom, $urandom});
        check($sformatf("%s clear_at_start", tag), get_r(inst) & ~ref_op(2'b11, 64'd0,
              64'd0, width(inst)) | (nslice(inst) == 1 ? 64'd0 : 64'd0), 64'd0);
        for (int c = 1; c <= n; c++) begin
            if (c > 1) tick();
            f = get_f(inst);
            check($sformatf("%s busy_done_c%0d", tag, c), {62'd0, f[1:0]}, 64'd2);
        end
        tick();
        f = get_f(inst);
        check($sformatf("%s done_c%0d", tag, n + 1), {62'd0, f[1:0]}, 64'd1);
        check($sformatf("%s result", tag), get_r(inst), exp);
        check($sformatf("%s nonzero", tag), {63'd0, f[2]}, {63'd0, exp != 64'd0});
        tick();
        f = get_f(inst);
        check($sformatf("%s idle_after", tag), {62'd0, f[1:0]}, 64'd0);
        check($sformatf("%s result_held", tag), get_r(inst), exp);
        check($sformatf("%s nonzero_held", tag), {63'd0, f[2]}, {63'd0, exp != 64'd0});
    endtask

    initial begin
        vec_t vecs[$];
        logic done_seen;
        logic busy_seen;
        logic [1:0]  rop;
        logic [63:0] ra, rb;

        vecs.push_back('{2'b01, 32'hF0F0_0000, 32'h0F0F_0001, 32'hFFFF_0001, 1'b1});
        vecs.push_back('{2'b00, 32'hAAAA_5555, 32'hFFFF_0000, 32'hAAAA_0000, 1'b1});
        vecs.push_back('{2'b01, 32'hAAAA_5555, 32'hFFFF_0000, 32'hFFFF_5555, 1'b1});
        vecs.push_back('{2'b10, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b1});
        vecs.push_back('{2'b11, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0000_AAAA, 1'b1});
        vecs.push_back('{2'b00, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1});

        reset = 1'b1;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 2'b00, 64'd0, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_result_%0d", i), get_r(i), 64'd0);
            check($sformatf("reset_flags_%0d", i), {61'd0, get_f(i)}, 64'd0);
        end
        reset = 1'b0;
        tick();

        // Directed table on the 32/8 instance
        foreach (vecs[k]) begin
            do_op(0, vecs[k].op, {32'd0, vecs[k].a}, {32'd0, vecs[k].b},
                  $sformatf("vec%0d", k));
            check($sformatf("vec%0d table_result", k), {32'd0, r0}, {32'd0, vecs[k].exp_r});
            check($sformatf("vec%0d table_nz", k), {63'd0, nz0}, {63'd0, vecs[k].exp_nz});
        end

        // Reset in the middle of RUN aborts with no done pulse
        drive(0, 1'b1, 2'b01, 64'h0000_0000_0000_00FF, 64'd0);
        tick();
        drive(0, 1'b0, 2'b01, 64'd0, 64'd0);
        tick();
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_result", {32'd0, r0}, 64'd0);
        check("midrun_reset_flags", {61'd0, nz0, bz0, dn0}, 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            done_seen |= dn0;
            busy_seen |= bz0;
        end
        check("midrun_reset_no_done", {63'd0, done_seen}, 64'd0);
        check("midrun_reset_idle", {63'd0, busy_seen}, 64'd0);

        // Start held through RUN and DONE with new operands: ignored until IDLE
        drive(0, 1'b1, 2'b01, 64'hF0F0_0000, 64'h0F0F_0001);          // cycle 0
        tick();                                                         // cycle 1
        drive(0, 1'b0, 2'b01, 64'hF0F0_0000, 64'h0F0F_0001);
        tick();                                                         // cycle 2
        drive(0, 1'b1, 2'b10, 64'h1111_2222, 64'h3333_0000);
        check("hs_busy_c2", {62'd0, bz0, dn0}, 64'd2);
        tick(); tick(); tick();                                         // cycle 5
        check("hs_done_c5", {62'd0, bz0, dn0}, 64'd1);
        check("hs_first_result", {32'd0, r0}, 64'hFFFF_0001);
        tick();                                                         // cycle 6 IDLE
        check("hs_idle_c6", {62'd0, bz0, dn0}, 64'd0);
        check("hs_result_held_c6", {32'd0, r0}, 64'hFFFF_0001);
        tick();                                                         // cycle 7
        drive(0, 1'b0, 2'b00, 64'd0, 64'd0);
        check("hs_accept_busy_c7", {62'd0, bz0, dn0}, 64'd2);
        tick(); tick(); tick();                                         // cycle 10
        check("hs_busy_c10", {62'd0, bz0, dn0}, 64'd2);
        tick();                                                         // cycle 11
        check("hs_done_c11", {62'd0, bz0, dn0}, 64'd1);
        check("hs_second_result", {32'd0, r0}, 64'h2222_2222);
        check("hs_second_nz", {63'd0, nz0}, 64'd1);
        tick();

        // Randomized sweep across all parameter sets
        for (int inst = 0; inst < 4; inst++) begin
            for (int k = 0; k < 12; k++) begin
                rop = 2'($urandom_range(0, 3));
                ra  = {$urandom, $urandom};
                rb  = {$urandom, $urandom};
                if (k == 0) begin
                    ra = 64'd0;
                    rb = 64'd0;
                end
                do_op(inst, rop, ra, rb, $sformatf("rnd_i%0d_k%0d", inst, k));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
